// File: rtl/mdio_arbiter.sv
// Round-robin arbiter sharing one MDIO transaction generator among N_REQ requesters.
// Optional read timeout enabled by defining MDIO_ARB_TIMEOUT_EN.
module mdio_arbiter #(
    parameter int N_REQ      = 4,
    parameter int WR_CYCLES  = 36,
    parameter int GAP_CYCLES = 2,
    parameter int RD_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*32-1:0]  req_frame,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic                 err,
    output logic [15:0]          rsp_data,
    output logic                 mdio_start,
    output logic [31:0]          t_data,
    input  logic                 gen_data_rdy,
    input  logic [15:0]          gen_rd_data
);
    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CMAX = (WR_CYCLES > RD_TIMEOUT) ? WR_CYCLES : RD_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMPLETE,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            is_read_q, is_read_d;
    logic [15:0]     rsp_data_q, rsp_data_d;
    logic [31:0]     t_data_q, t_data_d;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [31:0]     pick_frame;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            is_read_q  <= 1'b0;
            rsp_data_q <= '0;
            t_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            is_read_q  <= is_read_d;
            rsp_data_q <= rsp_data_d;
            t_data_q   <= t_data_d;
        end
    end

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!pick_found && req[(int'(rr_ptr_q) + k) % N_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = IW'((int'(rr_ptr_q) + k) % N_REQ);
            end
        end
        pick_frame = req_frame[int'(pick_idx)*32 +: 32];
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        is_read_d  = is_read_q;
        rsp_data_d = rsp_data_q;
        t_data_d   = t_data_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    idx_d    = pick_idx;
                    t_data_d = pick_frame;
                    if (pick_frame[29:28] == 2'b10 || pick_frame[29:28] == 2'b01) begin
                        is_read_d = (pick_frame[29:28] == 2'b10);
                        err_d     = 1'b0;
                        state_d   = S_ISSUE;
                    end else begin
                        err_d      = 1'b1;
                        rsp_data_d = '0;
                        state_d    = S_COMPLETE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = CW'(cnt_q + 1'b1);
                if (is_read_q) begin
                    if (gen_data_rdy) begin
                        rsp_data_d = gen_rd_data;
                        state_d    = S_COMPLETE;
`ifdef MDIO_ARB_TIMEOUT_EN
                    end else if (int'(cnt_q) == RD_TIMEOUT - 1) begin
                        err_d      = 1'b1;
                        rsp_data_d = '0;
                        state_d    = S_COMPLETE;
`endif
                    end
                end else if (int'(cnt_q) == WR_CYCLES) begin
                    // Count runs 0..WR_CYCLES so done lands WR_CYCLES+2 cycles after grant.
                    rsp_data_d = '0;
                    state_d    = S_COMPLETE;
                end
            end
            S_COMPLETE: begin
                rr_ptr_d = (int'(idx_q) == N_REQ - 1) ? '0 : IW'(idx_q + 1'b1);
                err_d    = 1'b0;
                cnt_d    = '0;
                state_d  = S_GAP;
            end
            S_GAP: begin
                cnt_d = CW'(cnt_q + 1'b1);
                if (int'(cnt_q) >= GAP_CYCLES - 1) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic busy;
    assign busy = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_COMPLETE);

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_out
            assign gnt[gi]  = busy && (idx_q == IW'(gi));
            assign done[gi] = (state_q == S_COMPLETE) && (idx_q == IW'(gi));
        end
    endgenerate

    assign mdio_start = (state_q == S_ISSUE);
    assign err        = err_q;
    assign rsp_data   = rsp_data_q;
    assign t_data     = t_data_q;
endmodule

// File: tb/tb_mdio_arbiter.sv
// Scoreboard bench for mdio_arbiter: directed transactions push expected
// completions; a negedge monitor pops and compares every done pulse.
module tb_mdio_arbiter;
    localparam int N_REQ      = 4;
    localparam int WR_CYCLES  = 36;
    localparam int GAP_CYCLES = 2;
    localparam int RD_TIMEOUT = 64;
    localparam int RD_LAT     = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic [N_REQ-1:0]    req;
    logic [N_REQ*32-1:0] req_frame;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    done;
    logic                err;
    logic [15:0]         rsp_data;
    logic                mdio_start;
    logic [31:0]         t_data;
    logic                gen_data_rdy;
    logic [15:0]         gen_rd_data;

    mdio_arbiter #(
        .N_REQ(N_REQ), .WR_CYCLES(WR_CYCLES), .GAP_CYCLES(GAP_CYCLES), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_frame(req_frame), .gnt(gnt), .done(done),
        .err(err), .rsp_data(rsp_data), .mdio_start(mdio_start), .t_data(t_data),
        .gen_data_rdy(gen_data_rdy), .gen_rd_data(gen_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        err;
        logic [15:0] rsp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   start_cnt = 0;
    logic gen_enable = 1'b1;
    logic [15:0] gen_value = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end else begin
            $display("ok   %s: %h (cycle %0d)", name, act, cyc);
        end
    endtask

    function automatic logic [31:0] mk_frame(input logic [1:0] op);
        return {2'b01, op, 5'd1, 5'd3, 2'b10, 16'h0000};
    endfunction

    // Monitor: every done pulse is matched against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && mdio_start) start_cnt++;
        if (!reset && done != '0) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=%b expected no completion", done);
            end else begin
                e = exp_q.pop_front();
                chk("mon_done", 32'(done), 32'(1 << e.idx));
                chk("mon_gnt_with_done", 32'(gnt), 32'(1 << e.idx));
                chk("mon_err", 32'(err), 32'(e.err));
                chk("mon_rsp_data", 32'(rsp_data), 32'(e.rsp));
            end
        end
    end

    // Generator model: read frames answer RD_LAT cycles after mdio_start.
    initial begin
        gen_data_rdy = 1'b0;
        gen_rd_data  = 16'h0000;
        forever begin
            @(negedge clk);
            if (!reset && mdio_start && t_data[29:28] == 2'b10 && gen_enable) begin
                repeat (RD_LAT) @(negedge clk);
                gen_data_rdy = 1'b1;
                gen_rd_data  = gen_value;
                @(negedge clk);
                gen_data_rdy = 1'b0;
                gen_rd_data  = 16'h0000;
            end
        end
    end

    task automatic wait_gnt(input int bit_i, output int at);
        at = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (gnt[bit_i]) begin
                at = cyc;
                return;
            end
        end
        chk("wait_gnt_timeout", 32'(gnt), 32'(1 << bit_i));
    endtask

    task automatic wait_done(input int bound, output int at);
        at = -1;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (done != '0) begin
                at = cyc;
                return;
            end
        end
        chk("wait_done_timeout", 32'(done), 32'hFFFF_FFFF);
    endtask

    int g_at, d_at, s0, gap_len;
    logic [N_REQ-1:0] rot [5];

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_frame = '0;
        repeat (3) @(negedge clk);
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_done_err", {done, err}, 32'h0);
        chk("reset_rsp_data", 32'(rsp_data), 32'h0);
        chk("reset_start_tdata", t_data | 32'(mdio_start), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Single read on requester 0.
        gen_value = 16'hBEEF;
        req_frame[31:0] = mk_frame(2'b10);
        s0 = start_cnt;
        exp_q.push_back('{idx: 0, err: 1'b0, rsp: 16'hBEEF});
        req = 4'b0001;
        wait_done(200, d_at);
        req = '0;
        chk("read_start_count", 32'(start_cnt - s0), 32'd1);

        // Single write on requester 2; frame change after grant is ignored.
        req_frame[95:64] = mk_frame(2'b01);
        exp_q.push_back('{idx: 2, err: 1'b0, rsp: 16'h0000});
        req = 4'b0100;
        wait_gnt(2, g_at);
        chk("rsp_held_after_read", 32'(rsp_data), 32'h0000_BEEF);
        req_frame[95:64] = mk_frame(2'b11);
        @(negedge clk);
        chk("write_tdata_latched", t_data, mk_frame(2'b01));
        wait_done(200, d_at);
        req = '0;
        chk("write_latency", 32'(d_at - g_at), 32'(WR_CYCLES + 2));

        // Bad opcode on requester 1.
        req_frame[63:32] = mk_frame(2'b11);
        s0 = start_cnt;
        exp_q.push_back('{idx: 1, err: 1'b1, rsp: 16'h0000});
        req = 4'b0010;
        wait_gnt(1, g_at);
        if (done == '0) wait_done(10, d_at);
        else d_at = cyc;
        req = '0;
        chk("badop_within_2", 32'(d_at - g_at <= 2), 32'd1);
        repeat (4) @(negedge clk);
        chk("badop_no_start", 32'(start_cnt - s0), 32'd0);

        // Reset during WAIT of a write on requester 3: no completion expected.
        req_frame[127:96] = mk_frame(2'b01);
        req = 4'b1000;
        wait_gnt(3, g_at);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset_gnt_done", {gnt, done}, 32'h0);
        chk("midreset_outputs", t_data | 32'(mdio_start) | 32'(err) | 32'(rsp_data), 32'h0);
        req = '0;
        @(negedge clk);
        reset = 1'b0;

        // Contention from rr_ptr=0: strict rotation 0,1,2,3,0 with idle gaps.
        gen_value = 16'h1234;
        req_frame = {mk_frame(2'b01), mk_frame(2'b00), mk_frame(2'b01), mk_frame(2'b10)};
        rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100; rot[3] = 4'b1000; rot[4] = 4'b0001;
        exp_q.push_back('{idx: 0, err: 1'b0, rsp: 16'h1234});
        exp_q.push_back('{idx: 1, err: 1'b0, rsp: 16'h0000});
        exp_q.push_back('{idx: 2, err: 1'b1, rsp: 16'h0000});
        exp_q.push_back('{idx: 3, err: 1'b0, rsp: 16'h0000});
        exp_q.push_back('{idx: 0, err: 1'b0, rsp: 16'h1234});
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            gap_len = 0;
            for (int n = 0; n < 100 && gnt == '0; n++) begin
                @(negedge clk);
                if (gnt == '0) gap_len++;
            end
            chk("rotation_gnt", 32'(gnt), 32'(rot[t]));
            if (t > 0) chk("gap_ge_min", 32'(gap_len >= GAP_CYCLES), 32'd1);
            if (done == '0) wait_done(200, d_at);
            if (t == 4) req = '0;
            @(negedge clk);
        end

        // Request dropped mid-transaction still completes; latched frame holds.
        gen_value = 16'hA5A5;
        req_frame[31:0] = mk_frame(2'b10);
        exp_q.push_back('{idx: 0, err: 1'b0, rsp: 16'hA5A5});
        req = 4'b0001;
        wait_gnt(0, g_at);
        req = '0;
        req_frame[31:0] = mk_frame(2'b01);
        @(negedge clk);
        chk("drop_tdata_latched", t_data, mk_frame(2'b10));
        wait_done(200, d_at);

`ifdef MDIO_ARB_TIMEOUT_EN
        // Read with data_rdy stuck low aborts after RD_TIMEOUT cycles.
        repeat (5) @(negedge clk);
        gen_enable = 1'b0;
        req_frame[63:32] = mk_frame(2'b10);
        exp_q.push_back('{idx: 1, err: 1'b1, rsp: 16'h0000});
        req = 4'b0010;
        wait_gnt(1, g_at);
        wait_done(RD_TIMEOUT + 20, d_at);
        req = '0;
        chk("timeout_latency_ge", 32'(d_at - g_at >= RD_TIMEOUT), 32'd1);
        gen_enable = 1'b1;
`endif

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end
endmodule
